turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Per-turn control FSM for the Chicken Cha-Cha-Cha board game. It sits directly upstream of the player-rotation counter. It accepts a tile flip from the current player and holds the tile face-up for a fixed reveal time. It then compares the tile against the image in front of the player's chicken. On a match it emits a move pulse and lets the same player continue. On a mismatch it emits the one-cycle `statecombo_next_turn` pulse that advances the rotation counter to the next player.

## Interface
- `REVEAL_CYCLES`, default 50_000_000: cycles the flipped tile stays revealed; legal range 1 .. 2^32-1.
- `TIMEOUT_CYCLES`, default 500_000_000: idle-flip timeout; used only when `TURN_TIMEOUT_EN` is defined.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  single-cycle pulse; starts a game (honoured in IDLE and DONE only)
- `flip`  in  1  single-cycle debounced button pulse (honoured in WAIT_FLIP only)
- `tile_id`  in  4  id of the tile being flipped; sampled on the `flip` cycle
- `target_id`  in  4  tile image in front of the current player's chicken; sampled in JUDGE
- `win`  in  1  level from the board logic: current player has reached the goal; sampled in SETTLE
- `state`  out  3  current FSM state encoding
- `reveal`  out  1  high while in REVEAL
- `advance`  out  1  one-cycle pulse: move the current chicken forward
- `statecombo_next_turn`  out  1  one-cycle pulse to the rotation counter
- `streak`  out  4  consecutive matches in the current turn
- `game_over`  out  1  high while in DONE

## Operation
State encodings:
- IDLE=000
- WAIT_FLIP=001
- REVEAL=010
- JUDGE=011
- MOVE=100
- NEXT=101
- DONE=110
- SETTLE=111

Outputs are Moore-decoded from the state register:
- `reveal` = (state==REVEAL)
- `advance` = (state==MOVE)
- `statecombo_next_turn` = (state==NEXT)
- `game_over` = (state==DONE)

Transitions:
- IDLE: on `start` → WAIT_FLIP, and `streak` is cleared to 0.
- WAIT_FLIP: on `flip` → REVEAL; latch `tile_id` into `tile_q`; load the timer with REVEAL_CYCLES-1.
- REVEAL: decrement the timer; when the timer reads 0 → JUDGE.
- JUDGE: `tile_q == target_id` → MOVE; otherwise → NEXT.
- MOVE: `streak` increments, saturating at 15; → SETTLE.
- SETTLE: `win` → DONE; otherwise → WAIT_FLIP (same player continues).
- NEXT: → WAIT_FLIP. `streak` is 0 in this cycle, because it is cleared on the edge entering NEXT.
- DONE: stays in DONE. On `start` → IDLE.

Ignored inputs:
- `flip` outside WAIT_FLIP has no effect; `tile_q` keeps its value.
- `start` outside IDLE/DONE has no effect.

Timer: a single 32-bit down-counter shared by REVEAL and the timeout.

## Timing
- Reset: `rst` high at an edge forces, from the next cycle:
  - state = IDLE
  - `tile_q` = 0, timer = 0, `streak` = 0
  - `reveal` = `advance` = `statecombo_next_turn` = `game_over` = 0
- Reset has priority over every other input in every state. Reset mid-REVEAL or mid-MOVE produces no further pulses.
- Flip sampled at edge k: REVEAL occupies cycles k+1 .. k+REVEAL_CYCLES; JUDGE is at k+REVEAL_CYCLES+1; MOVE or NEXT is at k+REVEAL_CYCLES+2.
- `advance` and `statecombo_next_turn` are each exactly one cycle wide and never high together.
- Between two `statecombo_next_turn` pulses there are at least REVEAL_CYCLES+2 low cycles, so the downstream edge-triggered counter sees one clean rising edge per turn.
- `flip` arriving in the same cycle as the SETTLE→WAIT_FLIP or NEXT→WAIT_FLIP transition is ignored. It is honoured only when `state` already reads WAIT_FLIP.

## Configuration
- `TURN_TIMEOUT_EN`
  - Defined: on entry to WAIT_FLIP the timer loads TIMEOUT_CYCLES-1. If the timer reaches 0 in WAIT_FLIP with no `flip` → NEXT, which forfeits the turn and clears `streak`. A `flip` in the same cycle as expiry wins and → REVEAL.
  - Undefined: WAIT_FLIP waits indefinitely and the timer is unused there. TIMEOUT_CYCLES is accepted but ignored.

## Test plan
Bench parameters: REVEAL_CYCLES=4, TIMEOUT_CYCLES=10.
- Reset: `rst` for 2 cycles → `state`=000, `streak`=0, all 1-bit outputs 0.
- Match: `start`; `flip` with `tile_id`=5, `target_id`=5, `win`=0.
  - → `reveal` high exactly 4 cycles, then JUDGE, then `advance` high 1 cycle.
  - → `streak`=1, state returns to 001, `statecombo_next_turn` never asserted.
- Mismatch after one match: `tile_id`=3, `target_id`=5.
  - → `statecombo_next_turn` high exactly 1 cycle, 6 cycles after the `flip` edge, with `state`=101 and `streak`=0.
- Win: matching flip with `win`=1.
  - → `state`=110 and `game_over`=1; a further `flip` is ignored.
  - `start` → `state`=000, `game_over`=0.
- Ignored input and reset: `flip` during REVEAL does not change `tile_q`; `rst` mid-REVEAL → IDLE next cycle, no `advance` or `statecombo_next_turn` pulse.
- Timeout: no `flip` for 10 cycles in WAIT_FLIP.
  - With `TURN_TIMEOUT_EN` → `statecombo_next_turn` pulses once.
  - Without it → still in 001 after 100 cycles.

Source files
------------

// File: rtl/turn_sequencer.sv
// Per-turn control FSM: flip -> timed reveal -> judge -> move (same player) or next turn.
// Optional idle-flip timeout is enabled by defining TURN_TIMEOUT_EN.
module turn_sequencer #(
   parameter int unsigned REVEAL_CYCLES  = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       flip,
   input  logic [3:0] tile_id,
   input  logic [3:0] target_id,
   input  logic       win,
   output logic [2:0] state,
   output logic       reveal,
   output logic       advance,
   output logic       statecombo_next_turn,
   output logic [3:0] streak,
   output logic       game_over
);

   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      WAIT_FLIP = 3'b001,
      REVEAL    = 3'b010,
      JUDGE     = 3'b011,
      MOVE      = 3'b100,
      NEXT      = 3'b101,
      DONE      = 3'b110,
      SETTLE    = 3'b111
   } state_t;

   localparam logic [31:0] REVEAL_LOAD  = 32'(REVEAL_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  tile_q;
   logic [31:0] timer;

   // The timer is reloaded with the timeout value on every WAIT_FLIP entry;
   // it only matters when the timeout feature is built in.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tile_q  <= 4'd0;
         timer   <= 32'd0;
         streak  <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= WAIT_FLIP;
                  streak  <= 4'd0;
                  timer   <= TIMEOUT_LOAD;
               end
            end
            WAIT_FLIP: begin
               if (flip) begin
                  state_q <= REVEAL;
                  tile_q  <= tile_id;
                  timer   <= REVEAL_LOAD;
               end
`ifdef TURN_TIMEOUT_EN
               else if (timer == 32'd0) begin
                  state_q <= NEXT;
                  streak  <= 4'd0;
               end else begin
                  timer <= timer - 32'd1;
               end
`endif
            end
            REVEAL: begin
               if (timer == 32'd0) begin
                  state_q <= JUDGE;
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            JUDGE: begin
               if (tile_q == target_id) begin
                  state_q <= MOVE;
               end else begin
                  state_q <= NEXT;
                  streak  <= 4'd0;
               end
            end
            MOVE: begin
               state_q <= SETTLE;
               if (streak != 4'hF) begin
                  streak <= streak + 4'd1;
               end
            end
            SETTLE: begin
               if (win) begin
                  state_q <= DONE;
               end else begin
                  state_q <= WAIT_FLIP;
                  timer   <= TIMEOUT_LOAD;
               end
            end
            NEXT: begin
               state_q <= WAIT_FLIP;
               timer   <= TIMEOUT_LOAD;
            end
            DONE: begin
               if (start) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign state                = state_q;
   assign reveal               = (state_q == REVEAL);
   assign advance              = (state_q == MOVE);
   assign statecombo_next_turn = (state_q == NEXT);
   assign game_over            = (state_q == DONE);

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with REVEAL_CYCLES=4, TIMEOUT_CYCLES=10.
module tb_turn_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       flip;
   logic [3:0] tile_id;
   logic [3:0] target_id;
   logic       win;
   logic [2:0] state;
   logic       reveal;
   logic       advance;
   logic       statecombo_next_turn;
   logic [3:0] streak;
   logic       game_over;

   int checks = 0;
   int errors = 0;

   turn_sequencer #(.REVEAL_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .flip                 (flip),
      .tile_id              (tile_id),
      .target_id            (target_id),
      .win                  (win),
      .state                (state),
      .reveal               (reveal),
      .advance              (advance),
      .statecombo_next_turn (statecombo_next_turn),
      .streak               (streak),
      .game_over            (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flip = 1'b0; tile_id = 4'd0; target_id = 4'd0; win = 1'b0;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (state !== 3'b000) begin errors++; $display("FAIL reset_state got %b want 000", state); end
      checks++;
      if (streak !== 4'd0) begin errors++; $display("FAIL reset_streak got %0d want 0", streak); end
      checks++;
      if ({reveal, advance, statecombo_next_turn, game_over} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", {reveal, advance, statecombo_next_turn, game_over});
      end
   endtask

   task automatic test_match();
      int reveal_cnt;
      int next_cnt;
      reveal_cnt = 0;
      next_cnt   = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (state !== 3'b001) begin errors++; $display("FAIL match_start got %b want 001", state); end
      tile_id = 4'd5; target_id = 4'd5; win = 1'b0; flip = 1'b1;
      step();
      flip = 1'b0;
      for (int i = 0; i < 4; i++) begin
         reveal_cnt += int'(reveal);
         next_cnt   += int'(statecombo_next_turn);
         step();
      end
      checks++;
      if (reveal_cnt != 4) begin errors++; $display("FAIL match_reveal_len got %0d want 4", reveal_cnt); end
      checks++;
      if (state !== 3'b011 || reveal !== 1'b0) begin
         errors++;
         $display("FAIL match_judge got state %b reveal %b want 011 0", state, reveal);
      end
      next_cnt += int'(statecombo_next_turn);
      step();
      checks++;
      if (advance !== 1'b1 || state !== 3'b100) begin
         errors++;
         $display("FAIL match_advance got adv %b state %b want 1 100", advance, state);
      end
      next_cnt += int'(statecombo_next_turn);
      step();
      checks++;
      if (advance !== 1'b0 || streak !== 4'd1) begin
         errors++;
         $display("FAIL match_settle got adv %b streak %0d want 0 1", advance, streak);
      end
      next_cnt += int'(statecombo_next_turn);
      step();
      checks++;
      if (state !== 3'b001) begin errors++; $display("FAIL match_return got %b want 001", state); end
      checks++;
      if (next_cnt != 0) begin errors++; $display("FAIL match_no_next got %0d want 0", next_cnt); end
   endtask

   task automatic test_mismatch();
      tile_id = 4'd3; target_id = 4'd5; flip = 1'b1;
      step();
      flip = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (statecombo_next_turn !== 1'b0) begin
         errors++;
         $display("FAIL mismatch_early got %b want 0", statecombo_next_turn);
      end
      step();
      checks++;
      if (statecombo_next_turn !== 1'b1 || state !== 3'b101 || streak !== 4'd0) begin
         errors++;
         $display("FAIL mismatch_next got nt %b state %b streak %0d want 1 101 0",
                  statecombo_next_turn, state, streak);
      end
      step();
      checks++;
      if (statecombo_next_turn !== 1'b0 || state !== 3'b001) begin
         errors++;
         $display("FAIL mismatch_width got nt %b state %b want 0 001", statecombo_next_turn, state);
      end
   endtask

   task automatic test_win();
      tile_id = 4'd9; target_id = 4'd9; win = 1'b1; flip = 1'b1;
      step();
      flip = 1'b0;
      for (int i = 0; i < 7; i++) step();
      checks++;
      if (state !== 3'b110 || game_over !== 1'b1 || streak !== 4'd1) begin
         errors++;
         $display("FAIL win_done got state %b go %b streak %0d want 110 1 1", state, game_over, streak);
      end
      win = 1'b0; flip = 1'b1;
      step();
      flip = 1'b0;
      checks++;
      if (state !== 3'b110) begin errors++; $display("FAIL win_flip_ignored got %b want 110", state); end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (state !== 3'b000 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL win_restart got state %b go %b want 000 0", state, game_over);
      end
   endtask

   task automatic test_ignored_and_reset();
      int pulses;
      pulses = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      tile_id = 4'd5; target_id = 4'd5; win = 1'b0; flip = 1'b1;
      step();
      tile_id = 4'd3;
      step();
      flip = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (advance !== 1'b1) begin
         errors++;
         $display("FAIL ignored_flip got adv %b state %b want adv 1", advance, state);
      end
      step();
      step();
      checks++;
      if (state !== 3'b001) begin errors++; $display("FAIL ignored_return got %b want 001", state); end
      tile_id = 4'd7; target_id = 4'd7; flip = 1'b1;
      step();
      flip = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (state !== 3'b000 || reveal !== 1'b0 || streak !== 4'd0) begin
         errors++;
         $display("FAIL midreveal_reset got state %b reveal %b streak %0d want 000 0 0", state, reveal, streak);
      end
      for (int i = 0; i < 10; i++) begin
         pulses += int'(advance) + int'(statecombo_next_turn);
         step();
      end
      checks++;
      if (pulses != 0 || state !== 3'b000) begin
         errors++;
         $display("FAIL reset_no_pulse got pulses %0d state %b want 0 000", pulses, state);
      end
   endtask

   task automatic test_timeout();
      int pulses;
      pulses = 0;
      flip = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (state !== 3'b001) begin errors++; $display("FAIL timeout_enter got %b want 001", state); end
`ifdef TURN_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         pulses += int'(statecombo_next_turn);
         step();
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL timeout_pulse got %0d want 1", pulses); end
`else
      for (int i = 0; i < 100; i++) begin
         pulses += int'(statecombo_next_turn);
         step();
      end
      checks++;
      if (pulses != 0 || state !== 3'b001) begin
         errors++;
         $display("FAIL timeout_wait got pulses %0d state %b want 0 001", pulses, state);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_win();
      test_ignored_and_reset();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
